// File: rtl/record_serializer.sv
// Frames TDC records as SYNC, SEQ, payload bytes (LSB first) and an XOR checksum for the host output mux.
// A one-record holding register lets the next record be accepted while the current frame drains.
module record_serializer #(
  parameter int          REC_WIDTH = 98,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [REC_WIDTH-1:0] rec_i,
  input  logic                 rec_valid_i,
  output logic                 rec_ready_o,
  output logic                 omux_req_o,
  input  logic                 omux_sel_i,
  output logic [7:0]           omux_data_o,
  output logic [15:0]          frames_o
);

  localparam int NBYTES = (REC_WIDTH + 7) / 8;
  localparam int SW     = NBYTES * 8;
  localparam logic [7:0] LAST_IDX = 8'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, SYNC, SEQ, DATA, CSUM} state_t;

  state_t               state_reg;
  logic [REC_WIDTH-1:0] hold_reg;
  logic                 hold_full_reg;
  logic [SW-1:0]        shift_reg;
  logic [7:0]           index_reg;
  logic [7:0]           seq_reg;
  logic [7:0]           csum_reg;
  logic [15:0]          frames_reg;

  logic accept;
  logic release_hold;

  assign accept       = rec_valid_i && !hold_full_reg;
  // The hold register empties either when idle or when the checksum byte of the current frame is consumed.
  assign release_hold = hold_full_reg &&
                        ((state_reg == IDLE) || (state_reg == CSUM && omux_sel_i));

  assign rec_ready_o = !hold_full_reg;
  assign frames_o    = frames_reg;
  assign omux_req_o  = (state_reg != IDLE);

  always_comb begin
    omux_data_o = 8'h00;
    case (state_reg)
      SYNC:    omux_data_o = SYNC_BYTE;
      SEQ:     omux_data_o = seq_reg;
      DATA:    omux_data_o = shift_reg[7:0];
      CSUM:    omux_data_o = csum_reg;
      default: omux_data_o = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
    end else begin
      if (accept) begin
        hold_reg <= rec_i;
      end
      if (accept) begin
        hold_full_reg <= 1'b1;
      end else if (release_hold) begin
        hold_full_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg  <= IDLE;
      shift_reg  <= '0;
      index_reg  <= 8'h00;
      seq_reg    <= 8'h00;
      csum_reg   <= 8'h00;
      frames_reg <= 16'h0000;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hold_full_reg) begin
            shift_reg <= SW'(hold_reg);
            csum_reg  <= 8'h00;
            state_reg <= SYNC;
          end
        end
        SYNC: begin
          if (omux_sel_i) state_reg <= SEQ;
        end
        SEQ: begin
          if (omux_sel_i) begin
            csum_reg  <= csum_reg ^ seq_reg;
            index_reg <= 8'h00;
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (omux_sel_i) begin
            csum_reg  <= csum_reg ^ shift_reg[7:0];
            shift_reg <= shift_reg >> 8;
            index_reg <= index_reg + 8'd1;
            if (index_reg == LAST_IDX) state_reg <= CSUM;
          end
        end
        CSUM: begin
          if (omux_sel_i) begin
            seq_reg    <= seq_reg + 8'd1;
            frames_reg <= frames_reg + 16'd1;
            // Chain straight into the next frame so no idle byte appears between frames.
            if (hold_full_reg) begin
              shift_reg <= SW'(hold_reg);
              csum_reg  <= 8'h00;
              state_reg <= SYNC;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_record_serializer.sv
// Directed bench for record_serializer: byte streams, pacing, back-to-back frames, seq wrap and reset abort.
module tb_record_serializer;

  localparam int RW = 98;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [RW-1:0] rec_i = '0;
  logic          rec_valid_i = 1'b0;
  logic          rec_ready_o;
  logic          omux_req_o;
  logic          omux_sel_i = 1'b0;
  logic [7:0]    omux_data_o;
  logic [15:0]   frames_o;

  record_serializer dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .rec_i       (rec_i),
    .rec_valid_i (rec_valid_i),
    .rec_ready_o (rec_ready_o),
    .omux_req_o  (omux_req_o),
    .omux_sel_i  (omux_sel_i),
    .omux_data_o (omux_data_o),
    .frames_o    (frames_o)
  );

  always #5 clk_i = ~clk_i;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] cap_q[$];
  logic [7:0] exp_b[0:63];
  int         gaps = 0;
  logic       gap_en = 1'b0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bytes are taken at the falling edge; a byte with sel high is consumed at the next rising edge.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (gap_en && cap_q.size() > 0 && cap_q.size() < 48 && !omux_req_o) gaps++;
      if (omux_req_o && omux_sel_i) cap_q.push_back(omux_data_o);
    end
  end

  task automatic fill_exp(input int base, input logic [RW-1:0] r, input logic [7:0] s);
    logic [103:0] p;
    logic [7:0]   c;
    p = 104'(r);
    c = s;
    exp_b[base]     = 8'hA5;
    exp_b[base + 1] = s;
    for (int i = 0; i < 13; i++) begin
      exp_b[base + 2 + i] = p[i*8 +: 8];
      c = c ^ p[i*8 +: 8];
    end
    exp_b[base + 15] = c;
  endtask

  task automatic do_reset();
    reset_i     = 1'b1;
    rec_valid_i = 1'b0;
    omux_sel_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    cap_q.delete();
  endtask

  // Presents a record (valid stays as the caller leaves it) and returns 1 ns after the accepting edge.
  task automatic offer_rec(input logic [RW-1:0] r);
    logic ok;
    rec_i       = r;
    rec_valid_i = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk_i);
      ok = rec_ready_o;
      @(posedge clk_i);
      #1;
    end
    if (!ok) check_vec("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int t;
    t = 0;
    while (cap_q.size() < n && t < budget) begin
      @(negedge clk_i);
      t++;
    end
    if (cap_q.size() < n) check_vec("byte_timeout", 32'(cap_q.size()), 32'(n));
  endtask

  task automatic cmp_frame(input string tag, input int qbase, input int ebase);
    for (int i = 0; i < 16; i++) begin
      if (qbase + i < cap_q.size())
        check_vec($sformatf("%s_b%0d", tag, i), 32'(cap_q[qbase + i]), 32'(exp_b[ebase + i]));
      else
        check_vec($sformatf("%s_b%0d_missing", tag, i), 32'd0, 32'd1);
    end
  endtask

  logic [RW-1:0] r2;
  logic [RW-1:0] recs[3];
  logic          toggle;

  initial begin
    // Reset state
    do_reset();
    check_vec("rst_req",    32'(omux_req_o),  32'd0);
    check_vec("rst_data",   32'(omux_data_o), 32'h00);
    check_vec("rst_ready",  32'(rec_ready_o), 32'd1);
    check_vec("rst_frames", 32'(frames_o),    32'd0);

    // Single record 98'h1, sel held high
    omux_sel_i = 1'b1;
    offer_rec(98'h1);
    rec_valid_i = 1'b0;
    check_vec("lat_e0_req", 32'(omux_req_o), 32'd0);
    check_vec("lat_e0_rdy", 32'(rec_ready_o), 32'd0);
    @(posedge clk_i); #1;
    check_vec("lat_e1_req",  32'(omux_req_o),  32'd1);
    check_vec("lat_e1_data", 32'(omux_data_o), 32'hA5);
    wait_bytes(16, 100);
    exp_b[0] = 8'hA5; exp_b[1] = 8'h00; exp_b[2] = 8'h01;
    for (int i = 3; i < 15; i++) exp_b[i] = 8'h00;
    exp_b[15] = 8'h01;
    cmp_frame("one", 0, 0);
    @(posedge clk_i); #1;
    check_vec("one_req_end", 32'(omux_req_o), 32'd0);
    check_vec("one_frames",  32'(frames_o),   32'd1);

    // Random record with sel toggling; seq is now 1
    cap_q.delete();
    r2 = RW'({$urandom(), $urandom(), $urandom(), $urandom()});
    fill_exp(0, r2, 8'h01);
    omux_sel_i = 1'b0;
    offer_rec(r2);
    rec_valid_i = 1'b0;
    toggle = 1'b0;
    for (int t = 0; t < 100 && cap_q.size() < 16; t++) begin
      toggle = ~toggle;
      omux_sel_i = toggle;
      @(negedge clk_i);
      if (!omux_sel_i && omux_req_o && cap_q.size() < 16)
        check_vec($sformatf("hold_b%0d", cap_q.size()), 32'(omux_data_o), 32'(exp_b[cap_q.size()]));
      @(posedge clk_i); #1;
    end
    omux_sel_i = 1'b0;
    cmp_frame("tgl", 0, 0);
    check_vec("tgl_frames", 32'(frames_o), 32'd2);

    // Three records back-to-back from reset
    do_reset();
    recs[0] = 98'h3_0123_4567_89AB_CDEF_0011_2233;
    recs[1] = 98'h1_FEDC_BA98_7654_3210_A5A5_5A5A;
    recs[2] = 98'h2_8000_0000_0000_0000_0000_0001;
    for (int k = 0; k < 3; k++) fill_exp(16 * k, recs[k], 8'(k));
    gaps = 0;
    gap_en = 1'b1;
    omux_sel_i = 1'b1;
    offer_rec(recs[0]);
    offer_rec(recs[1]);
    check_vec("b2b_rdy_full", 32'(rec_ready_o), 32'd0);
    offer_rec(recs[2]);
    check_vec("b2b_rdy_full2", 32'(rec_ready_o), 32'd0);
    rec_valid_i = 1'b0;
    wait_bytes(48, 200);
    gap_en = 1'b0;
    cmp_frame("b2b0", 0, 0);
    cmp_frame("b2b1", 16, 16);
    cmp_frame("b2b2", 32, 32);
    check_vec("b2b_gaps", 32'(gaps), 32'd0);
    @(posedge clk_i); #1;
    check_vec("b2b_frames", 32'(frames_o), 32'd3);

    // 257 frames: seq wraps to 00 on frame index 256
    do_reset();
    omux_sel_i = 1'b1;
    for (int k = 0; k < 257; k++) offer_rec(RW'(k));
    rec_valid_i = 1'b0;
    wait_bytes(257 * 16, 6000);
    for (int j = 254; j < 257; j++)
      if (j * 16 + 1 < cap_q.size())
        check_vec($sformatf("wrap_seq%0d", j), 32'(cap_q[j * 16 + 1]), 32'(j % 256));
    fill_exp(0, RW'(256), 8'h00);
    cmp_frame("wrap_last", 256 * 16, 0);
    @(posedge clk_i); #1;
    check_vec("wrap_frames", 32'(frames_o), 32'd257);

    // All-ones record
    do_reset();
    omux_sel_i = 1'b1;
    offer_rec({RW{1'b1}});
    rec_valid_i = 1'b0;
    wait_bytes(16, 100);
    exp_b[0] = 8'hA5; exp_b[1] = 8'h00;
    for (int i = 2; i < 14; i++) exp_b[i] = 8'hFF;
    exp_b[14] = 8'h03;
    exp_b[15] = 8'h03;
    cmp_frame("ones", 0, 0);

    // Reset during DATA with the holding register full
    do_reset();
    omux_sel_i = 1'b1;
    offer_rec(98'h1234);
    offer_rec(98'h5678);
    rec_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_vec("abort_pre_rdy", 32'(rec_ready_o), 32'd0);
    check_vec("abort_pre_req", 32'(omux_req_o),  32'd1);
    reset_i = 1'b1;
    #1;
    check_vec("abort_req", 32'(omux_req_o),  32'd0);
    check_vec("abort_rdy", 32'(rec_ready_o), 32'd1);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    cap_q.delete();
    fill_exp(0, 98'h9ABC, 8'h00);
    offer_rec(98'h9ABC);
    rec_valid_i = 1'b0;
    wait_bytes(16, 100);
    cmp_frame("restart", 0, 0);
    @(posedge clk_i); #1;
    check_vec("restart_frames", 32'(frames_o), 32'd1);
    check_vec("restart_idle",   32'(omux_req_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
